// File: rtl/shift_add_mult_pkg.sv
// Shared encodings for the shift-add multiplier controller.
// State values are fixed so traces stay readable across builds.
package shift_add_mult_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    TEST  = 3'd2,
    ADD   = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Iteration counter width; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/shift_add_mult_ctrl.sv
// Sequencer for a shift-add multiplier datapath.
// Moore FSM with outputs registered alongside the state.
module shift_add_mult_ctrl
  import shift_add_mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic lsb,
  output logic load,
  output logic clear,
  output logic add,
  output logic shift,
  output logic busy,
  output logic done
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t        state;
  logic [CW-1:0] cnt;

  // Next state, iteration count and the strobes that belong to it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      load  <= 1'b0;
      clear <= 1'b0;
      add   <= 1'b0;
      shift <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      load  <= 1'b0;
      clear <= 1'b0;
      add   <= 1'b0;
      shift <= 1'b0;
      done  <= 1'b0;
      busy  <= 1'b1;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= LOAD;
            load  <= 1'b1;
            clear <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        LOAD: begin
          state <= TEST;
          cnt   <= '0;
        end
        TEST: begin
          if (lsb) begin
            state <= ADD;
            add   <= 1'b1;
          end else begin
            state <= SHIFT;
            shift <= 1'b1;
          end
        end
        ADD: begin
          state <= SHIFT;
          shift <= 1'b1;
        end
        SHIFT: begin
          if (cnt == LAST) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            cnt   <= cnt + 1'b1;
            state <= TEST;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Bench for shift_add_mult_ctrl at WIDTH=4 and WIDTH=8.
// A behavioural datapath closes the lsb loop; results are checked against a*b.
module tb_shift_add_mult_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic st  = 1'b0;
  logic sel = 1'b0;
  logic [7:0] mp = '0;
  logic [7:0] mc = '0;

  logic start4, lsb4, load4, clear4, add4, shift4, busy4, done4;
  logic start8, lsb8, load8, clear8, add8, shift8, busy8, done8;
  logic [8:0]  p4;
  logic [16:0] p8;

  logic ld, cl, ad, sh, bz, dn;
  logic [16:0] prod;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  assign start4 = st & ~sel;
  assign start8 = st & sel;
  assign lsb4   = p4[0];
  assign lsb8   = p8[0];

  shift_add_mult_ctrl #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .lsb(lsb4),
    .load(load4), .clear(clear4), .add(add4), .shift(shift4),
    .busy(busy4), .done(done4)
  );

  shift_add_mult_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .lsb(lsb8),
    .load(load8), .clear(clear8), .add(add8), .shift(shift8),
    .busy(busy8), .done(done8)
  );

  // Behavioural datapaths driven by the strobes.
  always @(posedge clk) begin
    if (load4) begin
      p4[3:0] <= mp[3:0];
      if (clear4) p4[8:4] <= '0;
    end else if (add4) begin
      p4[8:4] <= p4[8:4] + {1'b0, mc[3:0]};
    end else if (shift4) begin
      p4 <= p4 >> 1;
    end
    if (load8) begin
      p8[7:0] <= mp;
      if (clear8) p8[16:8] <= '0;
    end else if (add8) begin
      p8[16:8] <= p8[16:8] + {1'b0, mc};
    end else if (shift8) begin
      p8 <= p8 >> 1;
    end
  end

  always_comb begin
    ld   = sel ? load8  : load4;
    cl   = sel ? clear8 : clear4;
    ad   = sel ? add8   : add4;
    sh   = sel ? shift8 : shift4;
    bz   = sel ? busy8  : busy4;
    dn   = sel ? done8  : done4;
    prod = sel ? p8 : {8'd0, p4};
  end

  // Request one multiply; returns at the negedge inside the done cycle.
  task automatic run_op(input int m, input int c, input bit keep);
    int    w;
    int    n;
    int    lat;
    string obs;
    string exp;
    bit    ovl;
    logic [16:0] want;
    w    = sel ? 8 : 4;
    lat  = 1 + 2 * w + $countones(m);
    want = 17'(m * c);
    exp  = "L";
    for (int i = 0; i < w; i++) begin
      exp = {exp, "T"};
      if (m[i]) exp = {exp, "A"};
      exp = {exp, "S"};
    end
    mp = m[7:0];
    mc = c[7:0];
    st = 1'b1;
    @(negedge clk);
    if (!keep) st = 1'b0;
    obs = "";
    n   = 0;
    ovl = 1'b0;
    while (dn !== 1'b1 && n < 64) begin
      if (bz !== 1'b1)      obs = {obs, "I"};
      else if (ld === 1'b1) obs = {obs, "L"};
      else if (ad === 1'b1) obs = {obs, "A"};
      else if (sh === 1'b1) obs = {obs, "S"};
      else                  obs = {obs, "T"};
      if ((int'(ld) + int'(ad) + int'(sh)) > 1 || cl !== ld)
        ovl = 1'b1;
      n++;
      @(negedge clk);
    end
    vectors++;
    if (n !== lat) begin
      errors++;
      $display("FAIL latency %0d*%0d: got %0d want %0d", m, c, n, lat);
    end
    vectors++;
    if (obs != exp) begin
      errors++;
      $display("FAIL sequence %0d*%0d: got %s want %s", m, c, obs, exp);
    end
    vectors++;
    if (ovl) begin
      errors++;
      $display("FAIL strobe_excl %0d*%0d: got overlap want none", m, c);
    end
    vectors++;
    if (dn !== 1'b1 || bz !== 1'b1) begin
      errors++;
      $display("FAIL done_cycle %0d*%0d: got done=%b busy=%b want 1 1",
               m, c, dn, bz);
    end
    vectors++;
    if (prod !== want) begin
      errors++;
      $display("FAIL product %0d*%0d: got %0d want %0d", m, c, prod, want);
    end
  endtask

  // One cycle after done with start low: back in idle, pulse gone.
  task automatic idle_check(input string tag);
    st = 1'b0;
    @(negedge clk);
    vectors++;
    if (dn !== 1'b0 || bz !== 1'b0 || (ld | cl | ad | sh) !== 1'b0) begin
      errors++;
      $display("FAIL idle_%s: got done=%b busy=%b strobes=%b%b%b%b want all 0",
               tag, dn, bz, ld, cl, ad, sh);
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    vectors++;
    if ({load4, clear4, add4, shift4, busy4, done4,
         load8, clear8, add8, shift8, busy8, done8} !== 12'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b%b%b%b%b%b want 000000",
               load4, clear4, add4, shift4, busy4, done4);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b done=%b want 0 0", busy4, done4);
    end
  endtask

  task automatic test_basic();
    sel = 1'b0;
    run_op(11, 13, 1'b0);
    idle_check("11x13");
    run_op(0, 9, 1'b0);
    idle_check("0x9");
    run_op(15, 15, 1'b0);
    idle_check("15x15");
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    run_op(3, 5, 1'b1);
    run_op(2, 7, 1'b0);
    idle_check("b2b");
  endtask

  task automatic test_reset_midop();
    sel = 1'b0;
    mp  = 8'd11;
    mc  = 8'd13;
    st  = 1'b1;
    @(negedge clk);
    st = 1'b0;
    repeat (5) @(negedge clk);
    vectors++;
    if (add4 !== 1'b1) begin
      errors++;
      $display("FAIL midop_add: got add=%b want 1", add4);
    end
    #1 rst = 1'b1;
    #1;
    vectors++;
    if ({load4, clear4, add4, shift4, busy4, done4} !== 6'd0) begin
      errors++;
      $display("FAIL async_reset: got %b%b%b%b%b%b want 000000",
               load4, clear4, add4, shift4, busy4, done4);
    end
    @(negedge clk);
    rst = 1'b0;
    idle_check("after_rst");
    run_op(6, 7, 1'b0);
    idle_check("6x7");
  endtask

  task automatic test_random();
    bit keep;
    sel = 1'b0;
    for (int i = 0; i < 16; i++) begin
      keep = (i < 15) ? 1'($urandom % 2) : 1'b0;
      run_op(int'($urandom % 16), int'($urandom % 16), keep);
      if (!keep) idle_check("rand4");
    end
  endtask

  task automatic test_width8();
    sel = 1'b1;
    @(negedge clk);
    run_op(255, 255, 1'b0);
    idle_check("255x255");
    for (int i = 0; i < 6; i++) begin
      run_op(int'($urandom % 256), int'($urandom % 256), 1'b0);
      idle_check("rand8");
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_reset_midop();
    test_random();
    test_width8();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/shift_add_mult_ctrl.md
Name: shift_add_mult_ctrl

Overview:
FSM controller that sequences the shift-add multiplier datapath through one unsigned WIDTH x WIDTH multiply per start request. It issues one-hot load/add/shift strobes, uses the datapath LSB to decide whether to add on each iteration, and counts WIDTH shift iterations. It reports busy and a one-cycle done pulse to the requester. It sits beside the datapath in a top-level multiplier wrapper.

Parameters:
WIDTH, 4, operand width in bits; must be >= 2; sets iteration count and counter width.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request a multiply; sampled only in IDLE or DONE
lsb  input  1  datapath product[0], current multiplier bit
load  output  1  datapath strobe: capture multiplier into product low half
clear  output  1  datapath strobe, coincident with load: zero product upper half [2*WIDTH:WIDTH]
add  output  1  datapath strobe: upper half += multiplicand
shift  output  1  datapath strobe: product >>= 1
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse; product valid while high

Behaviour:
- States: IDLE, LOAD, TEST, ADD, SHIFT, DONE. Moore outputs, registered state.
- Reset, asynchronous at any time including mid-operation: state=IDLE, iteration counter=0, and all outputs 0 immediately.
- IDLE: all strobes 0. start=1 -> LOAD; else stay.
- LOAD: load=1, clear=1, counter<=0 -> TEST.
- TEST: no strobes. lsb=1 -> ADD; lsb=0 -> SHIFT.
- ADD: add=1 -> SHIFT.
- SHIFT: shift=1. If counter==WIDTH-1 -> DONE, else counter<=counter+1 -> TEST.
- DONE: done=1, busy=1. start=1 -> LOAD (back-to-back accepted); else -> IDLE.
- Strobes load/add/shift are mutually exclusive in every cycle. clear only with load.
- Counter width: $clog2(WIDTH). Counter never wraps: the exit compare at WIDTH-1 precedes the increment.
- start is ignored in LOAD/TEST/ADD/SHIFT. It has no queuing or error flag.
- Latency: cycles from the start-accept edge to the first done cycle = 1 + 2*WIDTH + popcount(multiplier). Busy is high for that many cycles plus the DONE cycle.
- Requester holds multiplicand stable from start accept until done. The controller does not sample operands.
- lsb is sampled only in TEST. Its value in other states is don't-care.
- Product is valid in the DONE cycle and holds until the next load.

Decomposition:
- Package shift_add_mult_pkg: state encoding localparams (3-bit, IDLE=0 ... DONE=5) and a helper function for counter width.
- No sub-module inside the controller.
- Natural sibling: wrapper shift_add_multiplier_top instantiating this controller and the datapath. The wrapper ties lsb and the strobes, and forwards product/done. It is used as the integration test target.

Test Plan:
- Reset, then WIDTH=4, multiplier=11, multiplicand=13, pulse start -> strobe order L,T,A,S,T,A,S,T,S,T,A,S; busy 12 cycles; done pulse; product=143.
- multiplier=0, multiplicand=9 -> no add strobe, done 9 cycles after accept (1+8), product=0.
- multiplier=15, multiplicand=15 -> 4 add strobes, 13 busy cycles before done, product=225; assert load/add/shift never overlap.
- Hold start=1 continuously from 3*5 through 2*7 -> start ignored mid-op; second multiply starts from DONE with no IDLE cycle; products 15 then 14.
- Assert rst for 1 cycle during the second ADD of 11*13 -> outputs 0 asynchronously, state IDLE; next start runs 6*7 cleanly, product=42.
- WIDTH=8 build, 255*255 -> busy 1+16+8=25 cycles, product=65025, counter reaches 7 and exits without wrap.
